// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its receive-side sibling.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_tx_state_e;

    // Falling clock edges in one host-to-device frame, counting the ACK edge.
    localparam int PS2_FRAME_EDGES = 11;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic ps2OddParity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchronizer for the raw PS/2 clock and data pins, plus a
// falling-edge detector on the synchronized clock.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o
);

    logic [SYNC_STAGES-1:0] clkChain_q;
    logic [SYNC_STAGES-1:0] dataChain_q;
    logic                   clkPrev_q;

    // Shift the pins through the chains; idle-high lines reset to 1 so no false edge follows reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clkChain_q  <= '1;
            dataChain_q <= '1;
            clkPrev_q   <= 1'b1;
        end else begin
            clkChain_q  <= {clkChain_q[SYNC_STAGES-2:0], ps2_clk_i};
            dataChain_q <= {dataChain_q[SYNC_STAGES-2:0], ps2_data_i};
            clkPrev_q   <= clkChain_q[SYNC_STAGES-1];
        end
    end

    assign clk_sync_o  = clkChain_q[SYNC_STAGES-1];
    assign data_sync_o = dataChain_q[SYNC_STAGES-1];
    assign clk_fall_o  = clkPrev_q & ~clkChain_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts
// out one command byte on device clock falls and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    // The clock line is low for INHIBIT_CYCLES in total: the INHIBIT state
    // covers all but the last cycle, which is the REQ cycle.
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       STOP_EDGE = 4'(PS2_FRAME_EDGES - 1);

    ps2_tx_state_e    state_q, state_d;
    logic [7:0]       dataByte_q, dataByte_d;
    logic             parity_q, parity_d;
    logic [3:0]       edgeCnt_q, edgeCnt_d;
    logic [INH_W-1:0] inhCnt_q, inhCnt_d;
    logic [TO_W-1:0]  toCnt_q, toCnt_d;
    logic             txReady_q, txReady_d;
    logic             busy_q, busy_d;
    logic             txDone_q, txDone_d;
    logic             txError_q, txError_d;
    logic             clkOe_q, clkOe_d;
    logic             dataOe_q, dataOe_d;

    logic clkSync;
    logic dataSync;
    logic clkFall;
    logic accept;
    logic timeoutHit;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk_i   (ps2_clk_in),
        .ps2_data_i  (ps2_data_in),
        .clk_sync_o  (clkSync),
        .data_sync_o (dataSync),
        .clk_fall_o  (clkFall)
    );

    assign accept     = tx_valid & txReady_q;
    assign timeoutHit = (toCnt_q >= TO_LAST);

    // State and datapath registers; reset releases both bus lines at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dataByte_q <= '0;
            parity_q   <= 1'b0;
            edgeCnt_q  <= '0;
            inhCnt_q   <= '0;
            toCnt_q    <= '0;
            txReady_q  <= 1'b1;
            busy_q     <= 1'b0;
            txDone_q   <= 1'b0;
            txError_q  <= 1'b0;
            clkOe_q    <= 1'b0;
            dataOe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dataByte_q <= dataByte_d;
            parity_q   <= parity_d;
            edgeCnt_q  <= edgeCnt_d;
            inhCnt_q   <= inhCnt_d;
            toCnt_q    <= toCnt_d;
            txReady_q  <= txReady_d;
            busy_q     <= busy_d;
            txDone_q   <= txDone_d;
            txError_q  <= txError_d;
            clkOe_q    <= clkOe_d;
            dataOe_q   <= dataOe_d;
        end
    end

    // Next state, byte latch, fall counting and the saturating inhibit/timeout counters.
    always_comb begin
        state_d    = state_q;
        dataByte_d = dataByte_q;
        parity_d   = parity_q;
        edgeCnt_d  = edgeCnt_q;
        inhCnt_d   = '0;
        toCnt_d    = toCnt_q;
        case (state_q)
            IDLE: begin
                edgeCnt_d = '0;
                toCnt_d   = '0;
                if (accept) begin
                    dataByte_d = tx_data;
                    parity_d   = ps2OddParity(tx_data);
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                inhCnt_d = (inhCnt_q == '1) ? inhCnt_q : inhCnt_q + 1'b1;
                if (inhCnt_q == INH_LAST) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                toCnt_d = '0;
                state_d = SEND;
            end
            SEND: begin
                toCnt_d = (toCnt_q == '1) ? toCnt_q : toCnt_q + 1'b1;
                if (clkFall) begin
                    edgeCnt_d = edgeCnt_q + 1'b1;
                    if (edgeCnt_q + 1'b1 == STOP_EDGE) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                toCnt_d = (toCnt_q == '1) ? toCnt_q : toCnt_q + 1'b1;
                if (clkFall) begin
                    state_d = dataSync ? ERR : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                toCnt_d = (toCnt_q == '1) ? toCnt_q : toCnt_q + 1'b1;
                if (clkSync && dataSync) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if ((state_q inside {REQ, SEND, ACK, WAIT_IDLE}) && timeoutHit) begin
            state_d = ERR;
        end
    end

    // Registered outputs derived from the upcoming state; data bits change only on device clock falls.
    always_comb begin
        txReady_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
        txDone_d  = (state_d == DONE);
        txError_d = (state_d == ERR);
        clkOe_d   = (state_d == INHIBIT) || (state_d == REQ);
        dataOe_d  = dataOe_q;
        if ((state_q == SEND) && clkFall) begin
            if (edgeCnt_q < 4'd8) begin
                dataOe_d = ~dataByte_q[edgeCnt_q[2:0]];
            end else if (edgeCnt_q == 4'd8) begin
                dataOe_d = ~parity_q;
            end else begin
                dataOe_d = 1'b0;
            end
        end
        if (state_d == REQ) begin
            dataOe_d = 1'b1;
        end else if (!(state_d inside {SEND, ACK})) begin
            dataOe_d = 1'b0;
        end
    end

    assign tx_ready    = txReady_q;
    assign busy        = busy_q;
    assign tx_done     = txDone_q;
    assign tx_error    = txError_q;
    assign ps2_clk_oe  = clkOe_q;
    assign ps2_data_oe = dataOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 keyboard model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    // The system clock is modelled at 5 MHz so one 12.5 kHz PS/2 period is
    // 400 cycles and a full frame fits inside the shortened timeout.
    localparam int SYS_HALF = 5;
    localparam int DEV_HALF = 2000;
    localparam int INH      = 100;
    localparam int TO       = 20000;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;
    logic       devClk   = 1'b1;
    logic       devData  = 1'b1;
    wire        clkLine  = devClk & ~ps2_clk_oe;
    wire        dataLine = devData & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (clkLine),
        .ps2_data_in (dataLine),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Free-running system clock.
    always #(SYS_HALF) clock = ~clock;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cycle = 0, doneCount = 0, errorCount = 0, bothCount = 0;
    int          clkOeStart = 0, clkOeLen = 0, releaseCycle = 0, lastDoneCycle = 0, lastErrCycle = 0;
    bit          gapOk = 1'b1;
    logic        prevClkOe = 1'b0;
    logic [10:0] frame;
    int          d0, e0, busyDrops;
    logic [7:0]  t2Bytes [3] = '{8'h00, 8'hFF, 8'h01};
    logic        t2Par   [3] = '{1'b1, 1'b1, 1'b0};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse, accept-gap and clock-inhibit bookkeeping sampled away from the active edge.
    always @(negedge clock) begin
        cycle <= cycle + 1;
        if (tx_done) begin
            doneCount     <= doneCount + 1;
            lastDoneCycle <= cycle;
        end
        if (tx_error) begin
            errorCount   <= errorCount + 1;
            lastErrCycle <= cycle;
        end
        if (tx_done && tx_error) bothCount <= bothCount + 1;
        if (tx_valid && tx_ready && (doneCount > 0) && (cycle <= lastDoneCycle)) gapOk <= 1'b0;
        prevClkOe <= ps2_clk_oe;
        if (ps2_clk_oe && !prevClkOe) clkOeStart <= cycle;
        if (!ps2_clk_oe && prevClkOe) begin
            clkOeLen     <= cycle - clkOeStart;
            releaseCycle <= cycle;
        end
    end

    // Waits until the done+error total moves past a snapshot taken before the frame.
    task automatic waitPulse(input string tag, input int budget, input int startTotal);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (doneCount + errorCount > startTotal) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_wait"}, 32'(got), 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] value);
        @(negedge clock);
        tx_data  = value;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    // Keyboard model: waits for the request, clocks the frame and samples data on rising edges.
    task automatic deviceModel(input int abortFall, input bit ackDrive, input bit clockOn, output logic [10:0] bits);
        int guard;
        bits  = '1;
        guard = 0;
        while (clkLine !== 1'b0 && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("req_inhibit", 32'(clkLine), 32'd0);
        guard = 0;
        while (!(clkLine === 1'b1 && dataLine === 1'b0) && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("req_release", 32'({clkLine, dataLine}), 32'd2);
        bits[0] = dataLine;
        if (!clockOn) return;
        #(DEV_HALF);
        for (int n = 1; n <= 10; n++) begin
            devClk = 1'b0;
            if (n == abortFall) begin
                #(DEV_HALF / 2);
                @(negedge clock);
                #1;
                checkOutput("abort_data_oe_before", 32'(ps2_data_oe), 32'd1);
                reset = 1'b1;
                #1;
                checkOutput("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
                checkOutput("abort_data_oe", 32'(ps2_data_oe), 32'd0);
                devClk = 1'b1;
                return;
            end
            #(DEV_HALF);
            devClk  = 1'b1;
            bits[n] = dataLine;
            if (n == 10 && ackDrive) devData = 1'b0;
            #(DEV_HALF);
        end
        devClk = 1'b0;
        #(DEV_HALF);
        devClk = 1'b1;
        #(DEV_HALF / 2);
        devData = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tx_done", 32'(tx_done), 32'd0);
        checkOutput("rst_tx_error", 32'(tx_error), 32'd0);
        checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] test 1: set-LED command");
        d0 = doneCount; e0 = errorCount;
        applyStimulus(PS2_CMD_SET_LED);
        deviceModel(0, 1'b1, 1'b1, frame);
        waitPulse("t1", 2000, d0 + e0);
        checkOutput("t1_clk_oe_len", 32'(clkOeLen), 32'd100);
        checkOutput("t1_frame", 32'(frame), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        checkOutput("t1_done", 32'(doneCount - d0), 32'd1);
        checkOutput("t1_error", 32'(errorCount - e0), 32'd0);
        checkOutput("t1_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd0);

        $display("[TB] test 2: back-to-back bytes");
        d0 = doneCount;
        @(negedge clock);
        tx_data  = t2Bytes[0];
        tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e0 = doneCount + errorCount;
            deviceModel(0, 1'b1, 1'b1, frame);
            checkOutput("t2_data", 32'(frame[8:1]), 32'(t2Bytes[k]));
            checkOutput("t2_parity", 32'(frame[9]), 32'(t2Par[k]));
            waitPulse("t2", 2000, e0);
            if (k < 2) tx_data = t2Bytes[k + 1];
            else tx_valid = 1'b0;
        end
        checkOutput("t2_done", 32'(doneCount - d0), 32'd3);
        checkOutput("t2_gap", 32'(gapOk), 32'd1);

        $display("[TB] test 3: missing ACK");
        d0 = doneCount; e0 = errorCount;
        applyStimulus(PS2_CMD_RESET);
        deviceModel(0, 1'b0, 1'b1, frame);
        waitPulse("t3", 2000, d0 + e0);
        checkOutput("t3_error", 32'(errorCount - e0), 32'd1);
        checkOutput("t3_done", 32'(doneCount - d0), 32'd0);
        checkOutput("t3_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("t3_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("t3_tx_ready", 32'(tx_ready), 32'd1);

        $display("[TB] test 4: silent device timeout");
        d0 = doneCount; e0 = errorCount;
        applyStimulus(8'hF4);
        deviceModel(0, 1'b1, 1'b0, frame);
        waitPulse("t4", 25000, d0 + e0);
        checkOutput("t4_error", 32'(errorCount - e0), 32'd1);
        checkOutput("t4_latency", 32'(lastErrCycle - releaseCycle), 32'd20000);
        checkOutput("t4_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("t4_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("t4_done", 32'(doneCount - d0), 32'd0);

        $display("[TB] test 5: reset mid-frame");
        applyStimulus(PS2_CMD_SET_LED);
        deviceModel(5, 1'b1, 1'b1, frame);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t5_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        d0 = doneCount; e0 = errorCount;
        applyStimulus(PS2_CMD_SET_LED);
        deviceModel(0, 1'b1, 1'b1, frame);
        waitPulse("t5", 2000, d0 + e0);
        checkOutput("t5_frame", 32'(frame), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        checkOutput("t5_done", 32'(doneCount - d0), 32'd1);

        $display("[TB] test 6: tx_valid toggling while busy");
        d0 = doneCount; e0 = errorCount;
        busyDrops = 0;
        applyStimulus(8'hA5);
        tx_data = 8'h5A;
        fork
            deviceModel(0, 1'b1, 1'b1, frame);
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat (100) @(negedge clock);
                    tx_valid = ~tx_valid;
                    if (busy !== 1'b1) busyDrops++;
                end
                tx_valid = 1'b0;
            end
        join
        waitPulse("t6", 2000, d0 + e0);
        checkOutput("t6_data", 32'(frame[8:1]), 32'h A5);
        checkOutput("t6_parity", 32'(frame[9]), 32'd1);
        checkOutput("t6_busy_drops", 32'(busyDrops), 32'd0);
        checkOutput("t6_done", 32'(doneCount - d0), 32'd1);
        checkOutput("t6_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("both_pulses", 32'(bothCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
